led_ws2812b_serializer: RTL

Downstream consumer of the LED-driver Wishbone data fetcher. On `start` it pulls one 32-bit word per LED through the fetcher's first-word/next-word request interface. It serialises the low 24 bits of each word (GRB, MSB first) onto a single WS2812B data line using pulse-width encoding, then holds the line low for the latch/reset period. It keeps one word of look-ahead so consecutive LEDs are sent without gaps.

---
 rtl/led_ws2812b_serializer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/led_ws2812b_serializer.sv
`default_nettype none
// ============================================================================
// Module      : led_ws2812b_serializer
// Description : Fetches one word per LED and drives a WS2812B data line with
//               pulse-width encoded GRB bits, followed by the latch period.
// Revision    : 1.0 - initial release
// ============================================================================
module led_ws2812b_serializer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 63,
    parameter int RESET_CYCLES = 2500
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] led_count,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun,
    output logic                  wb_request_first_word,
    output logic                  wb_request_next_word,
    input  logic                  wb_recieved_new_word,
    input  logic [DATA_WIDTH-1:0] wb_received_word,
    output logic                  dout
);

    localparam int c_MAX_CYCLES = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0]    c_T0H        = c_CNT_W'(T0H_CYCLES);
    localparam logic [c_CNT_W-1:0]    c_T1H        = c_CNT_W'(T1H_CYCLES);
    localparam logic [c_CNT_W-1:0]    c_BIT_LAST   = c_CNT_W'(BIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_RESET_LAST = c_CNT_W'(RESET_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [4:0]            c_TOP_BIT    = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SEND  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_total;
    logic [ADDR_WIDTH-1:0] r_req_cnt;
    logic [ADDR_WIDTH-1:0] r_sent_cnt;
    logic                  r_outstanding;
    logic [23:0]           r_hold;
    logic                  r_hold_valid;
    logic [23:0]           r_shift;
    logic [4:0]            r_bit_idx;
    logic [c_CNT_W-1:0]    r_cnt;

    logic        w_accept;
    logic        w_strobe;
    logic        w_bit_end;
    logic        w_led_end;
    logic        w_frame_end;
    logic        w_word_ready;
    logic [23:0] w_next_word;
    logic        w_latch_end;
    logic        w_req_next;
    logic        w_load_shift;
    logic        w_underrun;
    logic        w_cnt_clr;
    logic        w_unused_upper;

    assign w_unused_upper = ^wb_received_word[DATA_WIDTH-1:24];

    assign w_accept    = (r_state == S_IDLE) && start && !busy;
    // Strobes are only meaningful against the single outstanding request.
    assign w_strobe    = wb_recieved_new_word && r_outstanding &&
                         ((r_state == S_WAIT) || (r_state == S_SEND));
    assign w_bit_end   = (r_state == S_SEND) && (r_cnt == c_BIT_LAST);
    assign w_led_end   = w_bit_end && (r_bit_idx == 5'd0);
    assign w_frame_end = w_led_end && ((r_sent_cnt + c_ADDR_ONE) == r_total);
    // A word landing exactly at the LED boundary is used directly, avoiding a needless underrun.
    assign w_word_ready = r_hold_valid || w_strobe;
    assign w_next_word  = r_hold_valid ? r_hold : wb_received_word[23:0];
    assign w_latch_end  = (r_state == S_LATCH) && (r_cnt == c_RESET_LAST);
    assign w_req_next   = ((r_state == S_WAIT) || (r_state == S_SEND)) &&
                          !r_outstanding && !r_hold_valid && (r_req_cnt < r_total);

    assign dout = (r_state == S_SEND) && (r_cnt < (r_shift[r_bit_idx] ? c_T1H : c_T0H));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_shift = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (led_count == '0) ? S_LATCH : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_strobe) begin
                    w_load_shift = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (w_led_end) begin
                    if (w_frame_end) begin
                        w_next_state = S_LATCH;
                    end else if (w_word_ready) begin
                        w_load_shift = 1'b1;
                    end else begin
                        w_underrun   = 1'b1;
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_LATCH: begin
                if (w_latch_end) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_cnt_clr = (w_next_state != r_state) || w_bit_end || w_load_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total               <= '0;
            r_req_cnt             <= '0;
            r_sent_cnt            <= '0;
            r_outstanding         <= 1'b0;
            r_hold                <= '0;
            r_hold_valid          <= 1'b0;
            r_shift               <= '0;
            r_bit_idx             <= '0;
            r_cnt                 <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            underrun              <= 1'b0;
            wb_request_first_word <= 1'b0;
            wb_request_next_word  <= 1'b0;
        end else begin
            done                  <= w_latch_end;
            underrun              <= w_underrun;
            wb_request_first_word <= w_accept && (led_count != '0);
            wb_request_next_word  <= w_req_next;

            // busy stays up through the done cycle so a start there is still rejected.
            if (w_accept) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if ((r_state == S_SEND) || (r_state == S_LATCH)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (w_accept) begin
                r_total       <= led_count;
                r_sent_cnt    <= '0;
                r_req_cnt     <= (led_count == '0) ? '0 : c_ADDR_ONE;
                r_outstanding <= (led_count != '0);
            end else begin
                if (w_led_end) begin
                    r_sent_cnt <= r_sent_cnt + c_ADDR_ONE;
                end
                if (w_req_next) begin
                    r_req_cnt     <= r_req_cnt + c_ADDR_ONE;
                    r_outstanding <= 1'b1;
                end else if (w_strobe) begin
                    r_outstanding <= 1'b0;
                end
            end

            if (w_load_shift) begin
                r_shift      <= w_next_word;
                r_bit_idx    <= c_TOP_BIT;
                r_hold_valid <= 1'b0;
            end else begin
                if (w_bit_end) begin
                    r_bit_idx <= r_bit_idx - 5'd1;
                end
                if (w_strobe) begin
                    r_hold       <= wb_received_word[23:0];
                    r_hold_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
